stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Stopwatch controller sequenced by the 10 ms tick from the tick generator. It holds a BCD mm:ss.cc count in centiseconds and runs a start/stop/lap/clear state machine. It freezes the displayed value during a lap and resynchronises the tick prescaler on each fresh start. It sits between the debounced button pulses and the seven-segment display driver.

## Interface
- HOLD_ON_WRAP, 0, behaviour at 59:59.99.
  - 0: wrap to 00:00.00 and keep counting.
  - 1: hold 59:59.99 and go to PAUSE.
- clk  in  1  on-board clock.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle pulse every 10 ms from the tick generator.
- start_stop  in  1  one-cycle debounced pulse.
- lap  in  1  one-cycle debounced pulse.
- clear  in  1  one-cycle debounced pulse.
- tg_rst  out  1  one-cycle pulse that resets the tick generator count.
- running  out  1  high in RUN and LAP.
- lap_active  out  1  high in LAP.
- wrap  out  1  one-cycle pulse on reaching or passing 59:59.99.
- disp_min_t, disp_min_u, disp_sec_t, disp_sec_u, disp_cs_t, disp_cs_u  out  4 each  BCD display digits.

## Operation
- States: IDLE, RUN, LAP, PAUSE.
- Input priority when pulses coincide: clear > start_stop > lap.
- IDLE
  - Count is held at 00:00.00.
  - start_stop: go to RUN and pulse tg_rst in the same cycle.
  - lap, clear and tick are ignored.
- RUN
  - Each tick advances the count by 0.01 s.
  - start_stop: go to PAUSE.
  - lap: go to LAP; the snapshot captures the count register value from before this cycle's update.
  - clear: go to IDLE and zero the count.
- LAP
  - The count keeps advancing on tick; the display shows the snapshot.
  - lap: go to RUN; the display goes live again.
  - start_stop: go to PAUSE; the display goes live and shows the stopped count.
  - clear: go to IDLE.
- PAUSE
  - tick is ignored.
  - start_stop: go to RUN with no tg_rst.
  - lap is ignored.
  - clear: go to IDLE.
- BCD arithmetic, all digits 4-bit:
  - cs_u 0–9; carry into cs_t 0–9.
  - Carry into sec_u 0–9, then sec_t 0–5.
  - Carry into min_u 0–9, then min_t 0–5.
- Wrap at 59:59.99 + tick:
  - HOLD_ON_WRAP=0: count becomes 00:00.00, wrap pulses, state is unchanged.
  - HOLD_ON_WRAP=1: count stays 59:59.99, wrap pulses, state becomes PAUSE.
  - In both cases a LAP snapshot, if active, is retained until exit from LAP.
- Display in live states (IDLE, RUN, PAUSE): disp registers load the same next value as the count, so disp equals count every cycle.
- Display in LAP: disp holds the snapshot.

## Timing
- All outputs are registered, except running and lap_active, which decode the state register.
- Reset values:
  - State IDLE; count 00:00.00; snapshot 0.
  - All disp digits 0.
  - tg_rst, wrap, running and lap_active all 0.
- The count and disp update in the clock edge following the cycle in which tick is high. Latency from tick to disp is 1 cycle.
- tick handling when it coincides with a pulse:
  - tick and start_stop in RUN: the tick is counted, then the state is PAUSE.
  - tick and start_stop in PAUSE: the tick is not counted.
  - tick and clear in RUN or LAP: clear wins, count is 00:00.00, the tick is lost.
  - tick and lap in RUN: the snapshot is the pre-tick value; the count still advances.
- tg_rst is high for exactly the one cycle after the IDLE→RUN edge.
- wrap is high for exactly the one cycle after the wrapping update.
- rst asserted in any state returns everything to reset values at the next edge; it overrides all inputs.

## Test plan
- rst, then start_stop, then 150 ticks → tg_rst one pulse, running=1, disp 00:01.50.
- RUN at 00:00.40, lap, then 25 ticks → lap_active=1, disp holds 00:00.40. Next lap → disp 00:00.65 on the following cycle.
- RUN, start_stop and tick in the same cycle at 00:00.09 → PAUSE, count 00:00.10. Further ticks change nothing. start_stop → RUN with no tg_rst.
- Preload to 59:59.99 via ticks, one more tick:
  - HOLD_ON_WRAP=0 → 00:00.00, wrap pulse, still RUN.
  - HOLD_ON_WRAP=1 → 59:59.99, wrap pulse, PAUSE.
- Carry check: count 00:09.99 + tick → 00:10.00; 09:59.99 + tick → 10:00.00.
- In LAP, clear together with start_stop and tick → IDLE, all disp 0. Then rst mid-RUN → all outputs at reset values at the next edge.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: mm:ss.cc BCD stopwatch advanced by the 10 ms tick.
// Runs the IDLE/RUN/LAP/PAUSE sequence, freezes the display on lap and
// pulses tg_rst on a fresh start so the first tick lands a full 10 ms later.
//
// state | meaning
// IDLE  | count held at 00:00.00, waiting for start
// RUN   | counting, display live
// LAP   | counting, display frozen on the lap snapshot
// PAUSE | count frozen, display live
module stopwatch_ctrl #(
    parameter bit HOLD_ON_WRAP = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    output logic       tg_rst,
    output logic       running,
    output logic       lap_active,
    output logic       wrap,
    output logic [3:0] disp_min_t,
    output logic [3:0] disp_min_u,
    output logic [3:0] disp_sec_t,
    output logic [3:0] disp_sec_u,
    output logic [3:0] disp_cs_t,
    output logic [3:0] disp_cs_u
);

    typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;

    state_t      state;
    // Digit packing, MSB to LSB: min_t, min_u, sec_t, sec_u, cs_t, cs_u
    logic [23:0] count;
    logic [23:0] snap;
    logic [23:0] disp;
    logic [23:0] cnt_inc;
    logic [23:0] count_tick;
    logic        c0, c1, c2, c3, c4, at_max, wrap_evt;

    // BCD increment with ripple carries; count_tick is the count after this cycle's tick
    always_comb begin
        c0     = (count[3:0]   == 4'd9);
        c1     = c0 && (count[7:4]   == 4'd9);
        c2     = c1 && (count[11:8]  == 4'd9);
        c3     = c2 && (count[15:12] == 4'd5);
        c4     = c3 && (count[19:16] == 4'd9);
        at_max = c4 && (count[23:20] == 4'd5);

        cnt_inc[3:0]   = c0 ? 4'd0 : count[3:0] + 4'd1;
        cnt_inc[7:4]   = c0 ? (c1 ? 4'd0 : count[7:4] + 4'd1)     : count[7:4];
        cnt_inc[11:8]  = c1 ? (c2 ? 4'd0 : count[11:8] + 4'd1)    : count[11:8];
        cnt_inc[15:12] = c2 ? (c3 ? 4'd0 : count[15:12] + 4'd1)   : count[15:12];
        cnt_inc[19:16] = c3 ? (c4 ? 4'd0 : count[19:16] + 4'd1)   : count[19:16];
        cnt_inc[23:20] = c4 ? (at_max ? 4'd0 : count[23:20] + 4'd1) : count[23:20];

        wrap_evt   = tick && at_max;
        count_tick = count;
        if (tick && !(at_max && HOLD_ON_WRAP)) begin
            count_tick = cnt_inc;
        end
    end

    // Sequencer: state, count, snapshot, display and the two output pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            snap   <= '0;
            disp   <= '0;
            tg_rst <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            tg_rst <= 1'b0;
            wrap   <= 1'b0;
            case (state)
                IDLE: begin
                    count <= '0;
                    disp  <= '0;
                    if (start_stop) begin
                        state  <= RUN;
                        tg_rst <= 1'b1;
                    end
                end
                RUN: begin
                    if (clear) begin
                        state <= IDLE;
                        count <= '0;
                        disp  <= '0;
                    end else begin
                        count <= count_tick;
                        wrap  <= wrap_evt;
                        if (start_stop || (wrap_evt && HOLD_ON_WRAP)) begin
                            state <= PAUSE;
                            disp  <= count_tick;
                        end else if (lap) begin
                            // snapshot is the value before this cycle's tick
                            state <= LAP;
                            snap  <= count;
                            disp  <= count;
                        end else begin
                            disp <= count_tick;
                        end
                    end
                end
                LAP: begin
                    if (clear) begin
                        state <= IDLE;
                        count <= '0;
                        disp  <= '0;
                    end else begin
                        count <= count_tick;
                        wrap  <= wrap_evt;
                        if (start_stop || (wrap_evt && HOLD_ON_WRAP)) begin
                            state <= PAUSE;
                            disp  <= count_tick;
                        end else if (lap) begin
                            state <= RUN;
                            disp  <= count_tick;
                        end else begin
                            disp <= snap;
                        end
                    end
                end
                PAUSE: begin
                    if (clear) begin
                        state <= IDLE;
                        count <= '0;
                        disp  <= '0;
                    end else if (start_stop) begin
                        state <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Status flags decode the state register directly
    assign running    = (state == RUN) || (state == LAP);
    assign lap_active = (state == LAP);

    assign {disp_min_t, disp_min_u, disp_sec_t, disp_sec_u, disp_cs_t, disp_cs_u} = disp;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: both HOLD_ON_WRAP variants driven in parallel,
// expectations queued per step and checked after each clock edge.
module tb_stopwatch_ctrl;

    logic clk = 1'b0;
    logic rst, tick, start_stop, lap, clear;

    logic       tg0, run0, la0, wr0, tg1, run1, la1, wr1;
    logic [3:0] m0t, m0u, s0t, s0u, c0t, c0u;
    logic [3:0] m1t, m1u, s1t, s1u, c1t, c1u;
    logic [23:0] d0, d1;

    int total = 0;
    int bad   = 0;
    int cnt   = 0;

    typedef struct {
        int          sel;
        string       tag;
        logic [23:0] d;
        logic        r;
        logic        la;
        logic        tg;
        logic        wr;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    stopwatch_ctrl #(.HOLD_ON_WRAP(1'b0)) u0 (
        .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .lap(lap), .clear(clear),
        .tg_rst(tg0), .running(run0), .lap_active(la0), .wrap(wr0),
        .disp_min_t(m0t), .disp_min_u(m0u), .disp_sec_t(s0t), .disp_sec_u(s0u),
        .disp_cs_t(c0t), .disp_cs_u(c0u)
    );

    stopwatch_ctrl #(.HOLD_ON_WRAP(1'b1)) u1 (
        .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .lap(lap), .clear(clear),
        .tg_rst(tg1), .running(run1), .lap_active(la1), .wrap(wr1),
        .disp_min_t(m1t), .disp_min_u(m1u), .disp_sec_t(s1t), .disp_sec_u(s1u),
        .disp_cs_t(c1t), .disp_cs_u(c1u)
    );

    assign d0 = {m0t, m0u, s0t, s0u, c0t, c0u};
    assign d1 = {m1t, m1u, s1t, s1u, c1t, c1u};

    // Centisecond count to packed BCD mm:ss.cc, computed arithmetically
    function automatic logic [23:0] bcd(input int cs);
        int m, s, c;
        m = cs / 6000;
        s = (cs / 100) % 60;
        c = cs % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    task automatic step(input logic r, input logic ss, input logic lp, input logic cl, input logic tk);
        rst = r; start_stop = ss; lap = lp; clear = cl; tick = tk;
        @(posedge clk);
        #1;
        rst = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0; tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic push1(input int sel, input string tag, input logic [23:0] d,
                         input logic r, input logic la, input logic tg, input logic wr);
        exp_t e;
        e.sel = sel; e.tag = tag; e.d = d; e.r = r; e.la = la; e.tg = tg; e.wr = wr;
        sb.push_back(e);
    endtask

    task automatic push2(input string tag, input logic [23:0] d,
                         input logic r, input logic la, input logic tg, input logic wr);
        push1(0, tag, d, r, la, tg, wr);
        push1(1, tag, d, r, la, tg, wr);
    endtask

    task automatic cmp(input string tag, input string fld, input logic [23:0] obs, input logic [23:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
        end
    endtask

    task automatic check_sb();
        exp_t e;
        logic [23:0] d;
        logic r, la, tg, wr;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.sel == 0) begin
                d = d0; r = run0; la = la0; tg = tg0; wr = wr0;
            end else begin
                d = d1; r = run1; la = la1; tg = tg1; wr = wr1;
            end
            cmp($sformatf("%s/h%0d", e.tag, e.sel), "disp",       d,          e.d);
            cmp($sformatf("%s/h%0d", e.tag, e.sel), "running",    24'(r),     24'(e.r));
            cmp($sformatf("%s/h%0d", e.tag, e.sel), "lap_active", 24'(la),    24'(e.la));
            cmp($sformatf("%s/h%0d", e.tag, e.sel), "tg_rst",     24'(tg),    24'(e.tg));
            cmp($sformatf("%s/h%0d", e.tag, e.sel), "wrap",       24'(wr),    24'(e.wr));
        end
    endtask

    // Load a count into both instances between edges
    task automatic preload(input logic [23:0] v);
        force u0.count = v;
        force u1.count = v;
        #1;
        release u0.count;
        release u1.count;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; tick = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
        @(negedge clk);

        // reset values
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        push2("reset", 24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_sb();

        // idle ignores tick/lap/clear
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        push2("idle_ign", 24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_sb();

        // start then 150 ticks
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cnt = 0;
        push2("start", bcd(cnt), 1'b1, 1'b0, 1'b1, 1'b0);
        check_sb();
        ticks(1);
        cnt = 1;
        push2("tg_once", bcd(cnt), 1'b1, 1'b0, 1'b0, 1'b0);
        check_sb();
        ticks(149);
        cnt = 150;
        push2("run150", bcd(cnt), 1'b1, 1'b0, 1'b0, 1'b0);
        check_sb();

        // lap freezes display at 00:00.40
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        push2("clear", 24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_sb();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(40);
        cnt = 40;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        push2("lap_in", bcd(cnt), 1'b1, 1'b1, 1'b0, 1'b0);
        check_sb();
        ticks(25);
        push2("lap_hold", bcd(40), 1'b1, 1'b1, 1'b0, 1'b0);
        check_sb();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cnt = 65;
        push2("lap_out", bcd(cnt), 1'b1, 1'b0, 1'b0, 1'b0);
        check_sb();

        // lap together with tick: snapshot is pre-tick, count advances
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        push2("lap_tick", bcd(65), 1'b1, 1'b1, 1'b0, 1'b0);
        check_sb();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cnt = 66;
        push2("lap_tick_out", bcd(cnt), 1'b1, 1'b0, 1'b0, 1'b0);
        check_sb();

        // start_stop + tick at 00:00.09
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(9);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        cnt = 10;
        push2("pause_tick", bcd(cnt), 1'b0, 1'b0, 1'b0, 1'b0);
        check_sb();
        ticks(5);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        push2("pause_ign", bcd(cnt), 1'b0, 1'b0, 1'b0, 1'b0);
        check_sb();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        push2("resume", bcd(cnt), 1'b1, 1'b0, 1'b0, 1'b0);
        check_sb();
        ticks(1);
        cnt = 11;
        push2("resume_tick", bcd(cnt), 1'b1, 1'b0, 1'b0, 1'b0);
        check_sb();

        // carry chains
        preload(bcd(999));
        ticks(1);
        push2("carry_sec", 24'h001000, 1'b1, 1'b0, 1'b0, 1'b0);
        check_sb();
        preload(bcd(59999));
        ticks(1);
        push2("carry_min", 24'h100000, 1'b1, 1'b0, 1'b0, 1'b0);
        check_sb();

        // wrap at 59:59.99
        preload(bcd(359999));
        ticks(1);
        push1(0, "wrap", 24'h000000, 1'b1, 1'b0, 1'b0, 1'b1);
        push1(1, "wrap", 24'h595999, 1'b0, 1'b0, 1'b0, 1'b1);
        check_sb();
        ticks(1);
        push1(0, "wrap_after", 24'h000001, 1'b1, 1'b0, 1'b0, 1'b0);
        push1(1, "wrap_after", 24'h595999, 1'b0, 1'b0, 1'b0, 1'b0);
        check_sb();

        // clear beats start_stop and tick in LAP
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(5);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        ticks(3);
        push2("lap_pre_clr", bcd(5), 1'b1, 1'b1, 1'b0, 1'b0);
        check_sb();
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        push2("lap_clear", 24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_sb();

        // reset mid-run overrides all inputs
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(7);
        push2("pre_rst", bcd(7), 1'b1, 1'b0, 1'b0, 1'b0);
        check_sb();
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        push2("mid_rst", 24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_sb();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        push2("post_rst_start", 24'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        check_sb();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
